// File: rtl/router_pkg.sv
// Shared constants and the router control FSM state encoding for the 1x3 router.
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_e;

endpackage

// File: rtl/router_reg_if.sv
// Bundle between the input port / control FSM (master) and the register stage (slave).
interface router_reg_if;
  import router_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              pkt_valid;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;

  modport master (
    output data_in, pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, write_enb_reg, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  data_in, pkt_valid, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, write_enb_reg, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );

endinterface

// File: rtl/router_parity_chk.sv
// Running XOR parity accumulator with a sticky mismatch flag for one packet.
module router_parity_chk
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] acc_byte,
  input  logic [DATA_W-1:0] packet_parity,
  input  logic              check,
  input  logic              done,
  input  logic              err_clr,
  output logic              err
);

  logic [DATA_W-1:0] int_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_par <= '0;
      err     <= 1'b0;
    end else begin
      // clear together with acc_en loads the byte instead of folding it in
      if (clear || acc_en)
        int_par <= (clear ? '0 : int_par) ^ (acc_en ? acc_byte : '0);
      if (err_clr)
        err <= 1'b0;
      else if (check)
        err <= done & (int_par != packet_parity);
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, payload/parity forwarding, full-byte hold.
// Parity checking is built only when ROUTER_PARITY_CHECK_EN is defined; otherwise err reads 0.
module router_reg
  import router_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  router_reg_if.slave  bus
);

  logic [DATA_W-1:0] hdr_byte;
  logic [DATA_W-1:0] full_byte;
  logic              full_is_par;
  logic [DATA_W-1:0] dout_q;
  logic              parity_done_q;
  logic              low_pkt_valid_q;
  logic              ld_parity;

  assign ld_parity = bus.write_enb_reg & ~bus.lfd_state & ~bus.ld_state & ~bus.laf_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_byte        <= '0;
      full_byte       <= '0;
      full_is_par     <= 1'b0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      if (bus.detect_add) begin
        parity_done_q <= 1'b0;
        if (bus.pkt_valid)
          hdr_byte <= bus.data_in;
      end
      if (bus.lfd_state)
        dout_q <= hdr_byte;
      if (bus.ld_state) begin
        if (!bus.fifo_full) begin
          dout_q <= bus.data_in;
          if (!bus.pkt_valid) begin
            low_pkt_valid_q <= 1'b1;
            parity_done_q   <= 1'b1;
          end
        end else begin
          full_byte   <= bus.data_in;
          full_is_par <= ~bus.pkt_valid;
          if (!bus.pkt_valid)
            low_pkt_valid_q <= 1'b1;
        end
      end
      if (bus.laf_state) begin
        dout_q <= full_byte;
        if (full_is_par)
          parity_done_q <= 1'b1;
      end
      if (ld_parity && !parity_done_q) begin
        dout_q          <= bus.data_in;
        parity_done_q   <= 1'b1;
        low_pkt_valid_q <= 1'b1;
      end
      if (bus.rst_int_reg)
        low_pkt_valid_q <= 1'b0;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] packet_parity;
  logic              acc_en;
  logic [DATA_W-1:0] acc_byte;

  always_ff @(posedge clk) begin
    if (rst)
      packet_parity <= '0;
    else if (bus.detect_add)
      packet_parity <= '0;
    else if (bus.ld_state && !bus.pkt_valid)
      packet_parity <= bus.data_in;
    else if (ld_parity && !parity_done_q)
      packet_parity <= bus.data_in;
  end

  always_comb begin
    acc_en   = 1'b0;
    acc_byte = '0;
    if (bus.lfd_state) begin
      acc_en   = 1'b1;
      acc_byte = hdr_byte;
    end else if (bus.ld_state && !bus.fifo_full && bus.pkt_valid) begin
      acc_en   = 1'b1;
      acc_byte = bus.data_in;
    end else if (bus.laf_state && !full_is_par) begin
      acc_en   = 1'b1;
      acc_byte = full_byte;
    end
  end

  router_parity_chk u_parity_chk (
    .clk           (clk),
    .rst           (rst),
    .clear         (bus.detect_add | bus.lfd_state),
    .acc_en        (acc_en),
    .acc_byte      (acc_byte),
    .packet_parity (packet_parity),
    .check         (bus.rst_int_reg),
    .done          (parity_done_q),
    .err_clr       (bus.detect_add & bus.pkt_valid),
    .err           (bus.err)
  );
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: packet-level model queues expected outputs, a monitor compares.
module tb_router_reg;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_reg_if bus();

  router_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  dout;
    logic        pd;
    logic        lpv;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_n  = 0;
  bit          stim_done = 1'b0;

  // Expected output state, derived from packet-level rules
  logic [7:0] m_dout = '0;
  logic       m_pd   = 1'b0;
  logic       m_lpv  = 1'b0;
  logic       m_err  = 1'b0;

  task automatic drive(input router_state_e st, input logic [7:0] d, input logic pv, input logic ff);
    bus.detect_add    = (st == DECODE_ADDRESS);
    bus.lfd_state     = (st == LOAD_FIRST_DATA);
    bus.ld_state      = (st == LOAD_DATA);
    bus.full_state    = (st == FIFO_FULL_STATE);
    bus.laf_state     = (st == LOAD_AFTER_FULL);
    bus.write_enb_reg = (st == LOAD_DATA) || (st == LOAD_AFTER_FULL) || (st == LOAD_PARITY);
    bus.rst_int_reg   = (st == CHECK_PARITY_ERROR);
    bus.data_in       = d;
    bus.pkt_valid     = pv;
    bus.fifo_full     = ff;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    e.dout = m_dout; e.pd = m_pd; e.lpv = m_lpv; e.err = m_err; e.cyc = cyc_n;
    sb.push_back(e);
    cyc_n++;
    #1;
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(255));
  endfunction

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] pl[8], input int unsigned n,
                             input logic [7:0] parity, input logic [8:0] stall,
                             input int unsigned full_cycles, input bit par_in_ld);
    logic [7:0]  xsum;
    logic [7:0]  b;
    bit          is_par;
    int unsigned nb;
    xsum = hdr;
    for (int unsigned i = 0; i < n; i++) xsum = xsum ^ pl[i];

    drive(DECODE_ADDRESS, hdr, 1'b1, 1'b0);
    m_pd = 1'b0; m_err = 1'b0;
    tick();
    drive(LOAD_FIRST_DATA, hdr, 1'b1, 1'b0);
    m_dout = hdr;
    tick();

    nb = n + (par_in_ld ? 1 : 0);
    for (int unsigned i = 0; i < nb; i++) begin
      is_par = (i == n);
      b = is_par ? parity : pl[i];
      drive(LOAD_DATA, b, !is_par, stall[i]);
      if (!stall[i]) begin
        m_dout = b;
        if (is_par) begin m_pd = 1'b1; m_lpv = 1'b1; end
      end else if (is_par) begin
        m_lpv = 1'b1;
      end
      tick();
      if (stall[i]) begin
        for (int unsigned k = 0; k < full_cycles; k++) begin
          drive(FIFO_FULL_STATE, rnd8(), 1'($urandom_range(1)), 1'b1);
          tick();
        end
        drive(LOAD_AFTER_FULL, rnd8(), !is_par, 1'b0);
        m_dout = b;
        if (is_par) m_pd = 1'b1;
        tick();
      end
    end

    drive(LOAD_PARITY, parity, 1'b0, 1'b0);
    if (!m_pd) begin m_dout = parity; m_pd = 1'b1; m_lpv = 1'b1; end
    tick();

    drive(CHECK_PARITY_ERROR, rnd8(), 1'b0, 1'b0);
    m_lpv = 1'b0;
`ifdef ROUTER_PARITY_CHECK_EN
    m_err = (xsum != parity);
`else
    m_err = 1'b0;
`endif
    tick();

    drive(WAIT_TILL_EMPTY, rnd8(), 1'b0, 1'b0);
    tick();
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp, input int unsigned c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("dout",          bus.dout,                 e.dout,         e.cyc);
      cmp("parity_done",   {7'd0, bus.parity_done},   {7'd0, e.pd},   e.cyc);
      cmp("low_pkt_valid", {7'd0, bus.low_pkt_valid}, {7'd0, e.lpv},  e.cyc);
      cmp("err",           {7'd0, bus.err},           {7'd0, e.err},  e.cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle=%0d expected stimulus to complete", cyc_n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0]  p[8];
    int unsigned n;
    logic [8:0]  stall;
    logic [7:0]  h;
    logic [7:0]  par;

    rst = 1'b1;
    drive(WAIT_TILL_EMPTY, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    p = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    // good packet, parity in load-parity
    send_packet(8'h0D, p, 3, 8'h0D, 9'b0, 0, 1'b0);
    // bad parity, err must hold through idle, then clear on the next header
    send_packet(8'h0D, p, 3, 8'hFF, 9'b0, 0, 1'b0);
    drive(WAIT_TILL_EMPTY, 8'h5A, 1'b0, 1'b0);
    tick();
    tick();
    // full while 8'h22 is presented, held 3 cycles
    send_packet(8'h0D, p, 3, 8'h0D, 9'b000000010, 3, 1'b0);
    // full while the parity byte is presented in ld_state
    send_packet(8'h0D, p, 3, 8'h0D, 9'b000001000, 2, 1'b1);
    // parity byte in ld_state without stall, invalid address header
    send_packet(8'h0F, p, 3, 8'h0F ^ 8'h11 ^ 8'h22 ^ 8'h33, 9'b0, 0, 1'b1);

    // reset mid-packet
    drive(DECODE_ADDRESS, 8'h0D, 1'b1, 1'b0);
    m_pd = 1'b0; m_err = 1'b0;
    tick();
    drive(LOAD_FIRST_DATA, 8'h0D, 1'b1, 1'b0);
    m_dout = 8'h0D;
    tick();
    drive(LOAD_DATA, 8'h11, 1'b1, 1'b0);
    m_dout = 8'h11;
    tick();
    rst = 1'b1;
    drive(LOAD_DATA, 8'h22, 1'b1, 1'b0);
    m_dout = '0; m_pd = 1'b0; m_lpv = 1'b0; m_err = 1'b0;
    tick();
    rst = 1'b0;
    p = '{8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_packet(8'h0E, p, 2, 8'h0E ^ 8'h44 ^ 8'h55, 9'b0, 0, 1'b0);

    for (int unsigned t = 0; t < 40; t++) begin
      n = $urandom_range(5, 1);
      for (int unsigned i = 0; i < 8; i++) p[i] = rnd8();
      h = {6'(n), 2'($urandom_range(3))};
      par = h;
      for (int unsigned i = 0; i < n; i++) par = par ^ p[i];
      if ($urandom_range(9) < 3) par = par ^ (8'h01 << $urandom_range(7));
      for (int unsigned i = 0; i < 9; i++) stall[i] = ($urandom_range(3) == 0);
      send_packet(h, p, n, par, stall, $urandom_range(3, 1), 1'($urandom_range(1)));
    end

    stim_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 router, driven by the router control FSM's state flags. Captures the header byte, streams payload and parity bytes to the output FIFOs, and holds the byte that arrived while the target FIFO was full. Accumulates a running XOR parity and flags a mismatch at packet end. Sits between the input port and the three output FIFOs, alongside the control FSM.

## Interface
- DATA_W, 8, byte width; header bits [1:0] are the destination address and [DATA_W-1:2] the payload length.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- data_in  in  DATA_W  byte from the source.
- pkt_valid  in  1  source byte valid; low while the parity byte is presented.
- fifo_full  in  1  the addressed output FIFO is full.
- detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state flags; at most one is high.
- write_enb_reg  in  1  FSM write enable; high with no lfd, ld or laf flag means the load-parity state.
- rst_int_reg  in  1  FSM check-parity state.
- dout  out  DATA_W  byte presented to the FIFOs.
- parity_done  out  1  the received parity byte has been forwarded.
- low_pkt_valid  out  1  pkt_valid has fallen for this packet.
- err  out  1  parity mismatch; sticky until the next header.

## Operation
On rst, every register and output is cleared to 0. Otherwise, per edge:
- **detect_add:** internal parity, parity_done and packet_parity are cleared. If pkt_valid is also high, hdr_byte <= data_in and err <= 0.
- **lfd_state:** dout <= hdr_byte; int_par <= hdr_byte.
- **ld_state, fifo_full low, pkt_valid high:** dout <= data_in; int_par ^= data_in.
- **ld_state, fifo_full low, pkt_valid low:** the parity byte. dout <= data_in, packet_parity <= data_in, low_pkt_valid <= 1, parity_done <= 1.
- **ld_state, fifo_full high:** full_byte <= data_in and full_is_par <= !pkt_valid. If the byte is the parity byte, packet_parity <= data_in and low_pkt_valid <= 1. dout holds.
- **full_state:** all registers hold.
- **laf_state:** dout <= full_byte. If full_is_par, parity_done <= 1; otherwise int_par ^= full_byte.
- **Load-parity (write_enb_reg high, no lfd/ld/laf flag), parity_done low:** dout <= data_in, packet_parity <= data_in, parity_done <= 1, low_pkt_valid <= 1. If parity_done is already high, everything holds.
- **rst_int_reg:** err <= parity_done & (int_par != packet_parity); low_pkt_valid <= 0.
- **Headers:** an address of 2'b11 is captured and forwarded unchanged; dropping it is the FSM's concern.
- **Source timing:** the source presents the header during detect_add and holds data_in during lfd_state, when busy is high. Payload starts in ld_state.

## Timing
- dout is registered and changes one edge after the qualifying cycle. The FIFO writes it in the following cycle, while write_enb_reg is high.
- The header reaches dout on the edge that closes lfd_state.
- err is valid on the edge that closes rst_int_reg and holds until the next detect_add with pkt_valid high.
- A synchronous rst in mid-packet clears everything on that edge. The next header is accepted normally.
- No back-pressure output. Stalls come only from the FSM holding full_state; data_in is ignored there.

## Configuration
- ROUTER_PARITY_CHECK_EN defined: int_par, packet_parity compare and err are built as above.
- ROUTER_PARITY_CHECK_EN undefined: int_par and the compare are removed and err is tied to 0. dout, parity_done and low_pkt_valid are unchanged, and the parity byte is still forwarded.

## Structure
- Shared package router_pkg holds:
  - DATA_W
  - address field width (2) and the invalid-address constant 2'b11
  - the FSM state encoding (3-bit values for DECODE_ADDRESS through WAIT_TILL_EMPTY)
- One sub-module, router_parity_chk, holds the accumulator and compare. It takes clear, accumulate enable, byte, packet_parity and check strobe, and outputs err. It is instantiated only under ROUTER_PARITY_CHECK_EN.

## Test plan
- **Good packet:** header 8'h0D, payload 8'h11/8'h22/8'h33, parity 8'h0D, fifo_full low -> dout sequence 0D,11,22,33,0D; parity_done=1 after the parity byte; err=0 after rst_int_reg.
- **Bad parity:** same packet with parity 8'hFF -> err=1 on the rst_int_reg edge; err stays 1 until the next header, then reads 0.
- **Full on payload:** fifo_full high while 8'h22 is in ld_state, then held for 3 cycles -> dout frozen at 11 through full_state; dout=22 after laf_state; parity 8'h0D then accepted in load-parity; err=0.
- **Full on parity byte:** fifo_full high while parity 8'h0D is presented -> low_pkt_valid=1 immediately; parity_done=1 only after laf_state; load-parity holds dout; err=0.
- **Reset mid-packet:** rst asserted during ld_state -> all outputs 0 on the next edge; the following header 8'h0E is captured correctly.
- **Macro off:** bad-parity packet with ROUTER_PARITY_CHECK_EN undefined -> err stays 0; the dout sequence is identical to the macro-on run.
